// File: rtl/dm_readback_pkg.sv
// Shared types and default widths for the data-memory read-out engine.
package dm_readback_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/rb_fifo.sv
// Small synchronous FIFO holding read-back words plus their last tag.
module rb_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // NOTE: the storage array has no reset; only pointers and count need one,
   // and an unreset array maps onto plain RAM or flops without reset fan-out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/dm_readback.sv
// Streams a contiguous block of DRAM words to the host over a valid/ready
// stream, throttling reads so the output buffer can never overflow.
module dm_readback
   import dm_readback_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic [ADDR_W-1:0] dm_addr,
   output logic              dm_rd_active,
   input  logic [DATA_W-1:0] dm_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] remaining;
   logic              inflight;
   logic              inflight_last;
   logic              issue;
   logic              pop;
   logic              last_xfer;
   logic              accept;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic [DATA_W:0]   head;
   logic [CW:0]       pending;

   rb_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inflight_last, dm_data}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // dm_addr doubles as the address counter: its current value is the read
   // issued this cycle, and it advances on the following edge.
   assign pending   = {1'b0, fifo_count} + (CW+1)'(inflight);
   assign issue     = (state == ST_RUN) && (pending < (CW+1)'(FIFO_DEPTH));
   assign accept    = (state == ST_IDLE) && start && (length != '0);
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign last_xfer = pop && head[DATA_W];
   assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
   assign out_last  = out_valid && head[DATA_W];

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (start) state_next = (length != '0) ? ST_RUN : ST_FINISH;
         end
         ST_RUN: begin
            if (issue && (remaining == ADDR_W'(1))) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (last_xfer) state_next = ST_FINISH;
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         dm_addr       <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_next;
         inflight      <= issue;
         inflight_last <= issue && (remaining == ADDR_W'(1));
         if (accept) begin
            dm_addr   <= base_addr;
            remaining <= length;
         end else if (issue) begin
            dm_addr   <= dm_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
         end
      end
   end

   // busy drops together with the done pulse, so FINISH counts as not busy.
   assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
   assign dm_rd_active = busy;
   assign done         = (state == ST_FINISH);

endmodule
